// File: rtl/ws2812_strip_driver.sv
// WS2812-family strip driver: streams NUM_PIXELS pixels MSB first, then holds the line low to latch.
// Optional build macro WS2812_UNDERRUN_PAD_EN pads a missing pixel with zeros instead of aborting the frame.
module ws2812_strip_driver #(
  parameter int INPUT_CLOCK    = 12_000_000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int NUM_PIXELS     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      busy,
  output logic                      underrun,
  output logic                      out
);

  localparam longint FCLK   = longint'(INPUT_CLOCK);
  localparam int     T0H    = int'(FCLK * 350 / 1_000_000_000);
  localparam int     T0L    = int'(FCLK * 700 / 1_000_000_000);
  localparam int     T1H    = int'(FCLK * 800 / 1_000_000_000);
  localparam int     T1L    = int'(FCLK * 600 / 1_000_000_000);
  localparam int     TRESET = int'(FCLK * 60 / 1_000_000);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), TRESET);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int PW   = $clog2(NUM_PIXELS + 1);

  localparam logic [CW-1:0] T0H_M    = CW'(T0H - 1);
  localparam logic [CW-1:0] T0L_M    = CW'(T0L - 1);
  localparam logic [CW-1:0] T1H_M    = CW'(T1H - 1);
  localparam logic [CW-1:0] T1L_M    = CW'(T1L - 1);
  localparam logic [CW-1:0] TRESET_M = CW'(TRESET - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);
  localparam logic [PW-1:0] NPIX     = PW'(NUM_PIXELS);

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [BITS_PER_PIXEL-1:0] shifter;
  logic [BITS_PER_PIXEL-1:0] shift_nxt;
  logic [BITS_PER_PIXEL-1:0] hold;
  logic                      hold_full;
  logic [PW-1:0]             accepted;
  logic [PW-1:0]             sent;
  logic                      hs;

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? T1H_M : T0H_M;
  endfunction

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? T1L_M : T0L_M;
  endfunction

  assign shift_nxt   = shifter << 1;
  assign pixel_ready = busy && (state != LATCH) && !hold_full && (accepted < NPIX);
  assign hs          = pixel_valid && pixel_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      accepted  <= '0;
      sent      <= '0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      out       <= 1'b0;
    end else begin
      underrun <= 1'b0;
      // Any handshake while a pixel is on the wire goes to the holding register;
      // the final-bit LOW branch below overrides this when it uses the pixel directly.
      if (hs && (state == HIGH || state == LOW)) begin
        hold      <= pixel_data;
        hold_full <= 1'b1;
        accepted  <= accepted + 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= LOAD;
            busy      <= 1'b1;
            accepted  <= '0;
            sent      <= '0;
            hold_full <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            shifter  <= pixel_data;
            bit_idx  <= LAST_BIT;
            cnt      <= high_len(pixel_data[BITS_PER_PIXEL-1]);
            accepted <= accepted + 1'b1;
            sent     <= sent + 1'b1;
            out      <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            cnt   <= low_len(shifter[BITS_PER_PIXEL-1]);
            out   <= 1'b0;
            state <= LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bit_idx != '0) begin
            shifter <= shift_nxt;
            bit_idx <= bit_idx - 1'b1;
            cnt     <= high_len(shift_nxt[BITS_PER_PIXEL-1]);
            out     <= 1'b1;
            state   <= HIGH;
          end else if (hold_full) begin
            shifter   <= hold;
            hold_full <= 1'b0;
            sent      <= sent + 1'b1;
            bit_idx   <= LAST_BIT;
            cnt       <= high_len(hold[BITS_PER_PIXEL-1]);
            out       <= 1'b1;
            state     <= HIGH;
          end else if (hs) begin
            shifter   <= pixel_data;
            hold_full <= 1'b0;
            sent      <= sent + 1'b1;
            bit_idx   <= LAST_BIT;
            cnt       <= high_len(pixel_data[BITS_PER_PIXEL-1]);
            out       <= 1'b1;
            state     <= HIGH;
          end else if (sent == NPIX) begin
            cnt   <= TRESET_M;
            state <= LATCH;
          end else begin
            underrun <= 1'b1;
`ifdef WS2812_UNDERRUN_PAD_EN
            shifter  <= '0;
            bit_idx  <= LAST_BIT;
            cnt      <= T0H_M;
            accepted <= accepted + 1'b1;
            sent     <= sent + 1'b1;
            out      <= 1'b1;
            state    <= HIGH;
`else
            cnt   <= TRESET_M;
            state <= LATCH;
`endif
          end
        end
        LATCH: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for ws2812_strip_driver: three instances (24b x1, 24b x3, 32b x1) at 12 MHz.
module tb_ws2812_strip_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        trig_a1, trig_a3, trig_w;
  logic        src_en;
  logic [31:0] src_vals [0:3];
  int          src_num;
  int          hs_base;
  int          hs_cnt = 0;
  int          ur_cnt = 0;
  int          src_idx;
  int          sel;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        ready_a1, ready_a3, ready_w;
  logic        busy_a1, busy_a3, busy_w;
  logic        ur_a1, ur_a3, ur_w;
  logic        out_a1, out_a3, out_w;
  logic        obs_out, obs_busy, obs_ready, obs_ur;

  assign src_idx     = hs_cnt - hs_base;
  assign pixel_valid = src_en && (src_idx < src_num);
  assign pixel_data  = (src_idx >= 0 && src_idx < 4) ? src_vals[src_idx] : 32'h0;

  assign obs_out   = (sel == 0) ? out_a1   : (sel == 1) ? out_a3   : out_w;
  assign obs_busy  = (sel == 0) ? busy_a1  : (sel == 1) ? busy_a3  : busy_w;
  assign obs_ready = (sel == 0) ? ready_a1 : (sel == 1) ? ready_a3 : ready_w;
  assign obs_ur    = (sel == 0) ? ur_a1    : (sel == 1) ? ur_a3    : ur_w;

  ws2812_strip_driver #(.INPUT_CLOCK(12_000_000), .BITS_PER_PIXEL(24), .NUM_PIXELS(1)) dut_a1 (
    .clk(clk), .rst(rst), .trigger(trig_a1), .pixel_data(pixel_data[23:0]),
    .pixel_valid(pixel_valid), .pixel_ready(ready_a1), .busy(busy_a1),
    .underrun(ur_a1), .out(out_a1));

  ws2812_strip_driver #(.INPUT_CLOCK(12_000_000), .BITS_PER_PIXEL(24), .NUM_PIXELS(3)) dut_a3 (
    .clk(clk), .rst(rst), .trigger(trig_a3), .pixel_data(pixel_data[23:0]),
    .pixel_valid(pixel_valid), .pixel_ready(ready_a3), .busy(busy_a3),
    .underrun(ur_a3), .out(out_a3));

  ws2812_strip_driver #(.INPUT_CLOCK(12_000_000), .BITS_PER_PIXEL(32), .NUM_PIXELS(1)) dut_w (
    .clk(clk), .rst(rst), .trigger(trig_w), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(ready_w), .busy(busy_w),
    .underrun(ur_w), .out(out_w));

  // Handshake and underrun tallies; both count what the DUTs saw during the previous cycle.
  always @(posedge clk) begin
    if (pixel_valid && (ready_a1 || ready_a3 || ready_w) && !rst) hs_cnt <= hs_cnt + 1;
    if (ur_a1 || ur_a3 || ur_w) ur_cnt <= ur_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which);
    if (which == 0) trig_a1 = 1'b1;
    else if (which == 1) trig_a3 = 1'b1;
    else trig_w = 1'b1;
    @(negedge clk);
    trig_a1 = 1'b0;
    trig_a3 = 1'b0;
    trig_w  = 1'b0;
  endtask

  // Measures one bit on the selected line: cycles high, then cycles low while busy.
  task automatic get_bit(output int hi, output int lo);
    int guard;
    guard = 0;
    hi = 0;
    lo = 0;
    while (obs_out !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    while (obs_out === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    while (obs_out === 1'b0 && obs_busy === 1'b1 && lo < 2000) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic check_pixel(input string tag, input logic [31:0] val, input int bits, input bit last);
    int hi, lo, exp_lo;
    logic b;
    for (int i = bits - 1; i >= 0; i--) begin
      b = val[i];
      get_bit(hi, lo);
      checkOutput($sformatf("%s bit%0d high", tag, i), hi, b ? 9 : 4);
      exp_lo = (b ? 7 : 8) + ((last && i == 0) ? 720 : 0);
      checkOutput($sformatf("%s bit%0d low", tag, i), lo, exp_lo);
    end
  endtask

  initial begin
    int hi, lo, ur0;
    rst = 1'b1;
    trig_a1 = 1'b0;
    trig_a3 = 1'b0;
    trig_w = 1'b0;
    src_en = 1'b0;
    src_num = 0;
    hs_base = 0;
    sel = 0;
    for (int i = 0; i < 4; i++) src_vals[i] = 32'h0;
    repeat (2) @(negedge clk);

    checkOutput("reset out", obs_out, 0);
    checkOutput("reset busy", obs_busy, 0);
    checkOutput("reset ready", obs_ready, 0);
    checkOutput("reset underrun", obs_ur, 0);
    trig_a1 = 1'b1;
    @(negedge clk);
    trig_a1 = 1'b0;
    checkOutput("trig in reset busy", obs_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("trig in reset stays idle", obs_busy, 0);
    checkOutput("idle ready", obs_ready, 0);

    $display("[TB] single pixel 0x800000 bit timing");
    sel = 0;
    src_vals[0] = 32'h0080_0000;
    hs_base = hs_cnt;
    src_num = 1;
    src_en = 1'b1;
    applyStimulus(0);
    checkOutput("start busy", obs_busy, 1);
    checkOutput("start ready", obs_ready, 1);
    checkOutput("start out low", obs_out, 0);
    check_pixel("single", 32'h0080_0000, 24, 1'b1);
    checkOutput("single busy done", obs_busy, 0);
    checkOutput("single handshakes", hs_cnt - hs_base, 1);
    src_en = 1'b0;

    $display("[TB] back-to-back three pixels");
    sel = 1;
    src_vals[0] = 32'h00FF_FFFF;
    src_vals[1] = 32'h0000_0000;
    src_vals[2] = 32'h00A5_A5A5;
    hs_base = hs_cnt;
    ur0 = ur_cnt;
    src_num = 3;
    src_en = 1'b1;
    applyStimulus(1);
    check_pixel("b2b p0", 32'h00FF_FFFF, 24, 1'b0);
    check_pixel("b2b p1", 32'h0000_0000, 24, 1'b0);
    check_pixel("b2b p2", 32'h00A5_A5A5, 24, 1'b1);
    checkOutput("b2b handshakes", hs_cnt - hs_base, 3);
    checkOutput("b2b no underrun", ur_cnt - ur0, 0);
    checkOutput("b2b busy done", obs_busy, 0);
    src_en = 1'b0;

    $display("[TB] RGBW pixel 0x00000001");
    sel = 2;
    src_vals[0] = 32'h0000_0001;
    hs_base = hs_cnt;
    src_num = 1;
    src_en = 1'b1;
    applyStimulus(2);
    check_pixel("rgbw", 32'h0000_0001, 32, 1'b1);
    checkOutput("rgbw busy done", obs_busy, 0);
    src_en = 1'b0;

    $display("[TB] underrun on second pixel");
    sel = 1;
    src_vals[0] = 32'h0012_3456;
    src_vals[1] = 32'h003C_0F01;
    hs_base = hs_cnt;
    ur0 = ur_cnt;
    src_num = 1;
    src_en = 1'b1;
    applyStimulus(1);
`ifdef WS2812_UNDERRUN_PAD_EN
    check_pixel("ur p0", 32'h0012_3456, 24, 1'b0);
    checkOutput("ur pulse", obs_ur, 1);
    src_num = 2;
    check_pixel("ur pad", 32'h0000_0000, 24, 1'b0);
    check_pixel("ur p2", 32'h003C_0F01, 24, 1'b1);
    checkOutput("ur handshakes", hs_cnt - hs_base, 2);
`else
    check_pixel("ur p0", 32'h0012_3456, 24, 1'b1);
    src_num = 2;
    repeat (3) @(negedge clk);
    checkOutput("ur handshakes", hs_cnt - hs_base, 1);
    checkOutput("ur ready after abort", obs_ready, 0);
`endif
    checkOutput("ur pulse count", ur_cnt - ur0, 1);
    checkOutput("ur busy done", obs_busy, 0);
    src_en = 1'b0;

    $display("[TB] mid-frame reset");
    sel = 0;
    src_vals[0] = 32'h00FF_FFFF;
    hs_base = hs_cnt;
    src_num = 1;
    src_en = 1'b1;
    applyStimulus(0);
    for (int i = 0; i < 10; i++) get_bit(hi, lo);
    checkOutput("mid in high phase", obs_out, 1);
    src_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid rst out", obs_out, 0);
    checkOutput("mid rst busy", obs_busy, 0);
    checkOutput("mid rst ready", obs_ready, 0);
    checkOutput("mid rst underrun", obs_ur, 0);
    src_vals[0] = 32'h000F_00F0;
    hs_base = hs_cnt;
    src_en = 1'b1;
    applyStimulus(0);
    checkOutput("restart ready", obs_ready, 1);
    check_pixel("restart", 32'h000F_00F0, 24, 1'b1);
    checkOutput("restart handshakes", hs_cnt - hs_base, 1);
    src_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
